// File: rtl/calc_pkg.sv
// Purpose: shared types and constants for the calculator operand-entry slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package calc_pkg;

    // Operator key / latched operator encoding.
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_ADD   = 3'd1,
        OP_SUB   = 3'd2,
        OP_MUL   = 3'd3,
        OP_CLEAR = 3'd4
    } op_e;

    // Entry FSM states.
    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_REQ = 2'd2
    } state_e;

    // Largest magnitude an operand may hold.
    localparam int unsigned MAX_MAG = 32767;

    // Digit codes at or above this value are invalid.
    localparam logic [3:0] DIGIT_LIMIT = 4'd10;

endpackage

// File: rtl/operand_entry_if.sv
// Purpose: keypad-side and ALU-side signals of operand_entry, grouped as one bundle.
// Latency: n/a (wiring only).
// Backpressure: KeyRd acknowledges keys; calc_req is held until calc_ack.
// Ports: master = keypad scanner / ALU environment, slave = operand_entry.
interface operand_entry_if;
    logic               KeyRdy;
    logic               KeyRd;
    logic        [3:0]  keypad_input;
    logic        [2:0]  operator_input;
    logic               equal_input;
    logic signed [15:0] operand_a;
    logic signed [15:0] operand_b;
    logic        [2:0]  op_code;
    logic               calc_req;
    logic               calc_ack;
    logic signed [15:0] display_value;

    modport master (
        output KeyRdy, keypad_input, operator_input, equal_input, calc_ack,
        input  KeyRd, operand_a, operand_b, op_code, calc_req, display_value
    );

    modport slave (
        input  KeyRdy, keypad_input, operator_input, equal_input, calc_ack,
        output KeyRd, operand_a, operand_b, op_code, calc_req, display_value
    );
endinterface

// File: rtl/digit_accum.sv
// Purpose: one operand's magnitude/sign/digit-seen state; accumulates decimal digits, saturating at MAX_MAG.
// Latency: update visible on the output one cycle after the enable edge.
// Backpressure: none; acts on the enables it is given.
// Ports: clear (highest priority), digit_en + digit, sign_toggle; outputs signed value and has_digit.
module digit_accum
    import calc_pkg::*;
(
    input  logic               clk,
    input  logic               nRST,
    input  logic               clear,
    input  logic               digit_en,
    input  logic        [3:0]  digit,
    input  logic               sign_toggle,
    output logic               has_digit,
    output logic signed [15:0] value
);

    localparam logic [19:0] MAX_MAG_W = 20'(MAX_MAG);

    logic [14:0] mag_q, mag_d;
    logic        neg_q, neg_d;
    logic        has_q, has_d;
    logic [19:0] acc;
    logic [15:0] mag_ext;

    // 32767*10+9 needs 19 bits; 20 keeps a margin so the overflow test is exact.
    always_comb begin
        acc   = 20'(mag_q) * 20'd10 + 20'(digit);
        mag_d = mag_q;
        neg_d = neg_q;
        has_d = has_q;
        if (clear) begin
            mag_d = '0;
            neg_d = 1'b0;
            has_d = 1'b0;
        end else begin
            if (digit_en) begin
                // An overflowing digit is dropped; the digit flag is left untouched.
                if (acc <= MAX_MAG_W) begin
                    mag_d = acc[14:0];
                    has_d = 1'b1;
                end
            end
            if (sign_toggle) begin
                neg_d = ~neg_q;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            mag_q <= '0;
            neg_q <= 1'b0;
            has_q <= 1'b0;
        end else begin
            mag_q <= mag_d;
            neg_q <= neg_d;
            has_q <= has_d;
        end
    end

    // Negating a zero magnitude yields zero, so -0 never reaches the output.
    always_comb begin
        mag_ext   = {1'b0, mag_q};
        value     = neg_q ? signed'(16'd0 - mag_ext) : signed'(mag_ext);
        has_digit = has_q;
    end

endmodule

// File: rtl/operand_entry.sv
// Purpose: keypad operand-entry FSM; builds signed operands A/B plus operator and requests a calculation.
// Latency: key effect applied at the capture edge, KeyRd and calc_req visible the following cycle.
// Backpressure: keys are not consumed while a request is pending (S_REQ); calc_req holds until calc_ack.
// Ports: clk, nRST (async active-low), bus (operand_entry_if.slave: key handshake, operands, ALU handshake).
module operand_entry
    import calc_pkg::*;
(
    input  logic            clk,
    input  logic            nRST,
    operand_entry_if.slave  bus
);

    state_e state_q, state_d;
    op_e    op_code_q, op_code_d;
    logic   armed_q, armed_d;
    logic   key_rd_q, key_rd_d;

    logic   capture;
    logic   in_b;
    logic   cur_has;
    op_e    key_op;
    logic   clr_all;
    logic   dig_a, dig_b;
    logic   tog_a, tog_b;
    logic   has_a, has_b;
    logic signed [15:0] val_a, val_b;

    // A key is taken only once per KeyRdy rise: armed re-arms on any sampled KeyRdy=0.
    assign capture = bus.KeyRdy && armed_q && (state_q != S_REQ);
    assign key_op  = op_e'(bus.operator_input);
    assign in_b    = (state_q == S_B);
    assign cur_has = in_b ? has_b : has_a;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_A;
            op_code_q <= OP_NONE;
            armed_q   <= 1'b0;
            key_rd_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_code_q <= op_code_d;
            armed_q   <= armed_d;
            key_rd_q  <= key_rd_d;
        end
    end

    // Next-state and datapath controls. Key field priority: CLEAR, equals, operator, digit.
    always_comb begin
        state_d   = state_q;
        op_code_d = op_code_q;
        armed_d   = capture ? 1'b0 : (bus.KeyRdy ? armed_q : 1'b1);
        key_rd_d  = capture;
        clr_all   = 1'b0;
        dig_a     = 1'b0;
        dig_b     = 1'b0;
        tog_a     = 1'b0;
        tog_b     = 1'b0;
        if (state_q == S_REQ) begin
            if (bus.calc_ack) begin
                clr_all   = 1'b1;
                op_code_d = OP_NONE;
                state_d   = S_A;
            end
        end else if (capture) begin
            if (key_op == OP_CLEAR) begin
                clr_all   = 1'b1;
                op_code_d = OP_NONE;
                state_d   = S_A;
            end else if (bus.equal_input) begin
                if (in_b && has_b) begin
                    state_d = S_REQ;
                end
            end else if (key_op == OP_ADD || key_op == OP_SUB || key_op == OP_MUL) begin
                if (!cur_has) begin
                    // Leading minus: SUB before any digit flips the current operand's sign.
                    if (key_op == OP_SUB) begin
                        tog_a = !in_b;
                        tog_b = in_b;
                    end
                end else if (!in_b) begin
                    op_code_d = key_op;
                    state_d   = S_B;
                end
            end else if (key_op == OP_NONE && bus.keypad_input < DIGIT_LIMIT) begin
                dig_a = !in_b;
                dig_b = in_b;
            end
            // Invalid digit codes and reserved operators fall through: consumed, no effect.
        end
    end

    digit_accum u_accum_a (
        .clk         (clk),
        .nRST        (nRST),
        .clear       (clr_all),
        .digit_en    (dig_a),
        .digit       (bus.keypad_input),
        .sign_toggle (tog_a),
        .has_digit   (has_a),
        .value       (val_a)
    );

    digit_accum u_accum_b (
        .clk         (clk),
        .nRST        (nRST),
        .clear       (clr_all),
        .digit_en    (dig_b),
        .digit       (bus.keypad_input),
        .sign_toggle (tog_b),
        .has_digit   (has_b),
        .value       (val_b)
    );

    always_comb begin
        bus.KeyRd         = key_rd_q;
        bus.calc_req      = (state_q == S_REQ);
        bus.operand_a     = val_a;
        bus.operand_b     = val_b;
        bus.op_code       = op_code_q;
        bus.display_value = (state_q == S_A) ? val_a : val_b;
    end

endmodule

// File: tb/tb_operand_entry.sv
// Purpose: directed self-checking bench for operand_entry (entry, signs, saturation, handshakes, reset).
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: key presses wait a bounded number of cycles for KeyRd.
module tb_operand_entry;

    logic clk;
    logic nRST;
    int   pass_cnt;
    int   total_cnt;

    operand_entry_if bus();

    operand_entry dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one key, wait for its acknowledge, then release KeyRdy for a cycle.
    task automatic press(input logic [3:0] kp, input logic [2:0] op, input logic eq);
        bit got;
        got = 1'b0;
        bus.keypad_input   = kp;
        bus.operator_input = op;
        bus.equal_input    = eq;
        bus.KeyRdy         = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.KeyRd === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        total_cnt++;
        if (!got) $display("FAIL press_ack kp=%0d op=%0d eq=%0d: KeyRd never seen, required 1", kp, op, eq);
        else pass_cnt++;
        bus.KeyRdy         = 1'b0;
        bus.keypad_input   = 4'd0;
        bus.operator_input = 3'd0;
        bus.equal_input    = 1'b0;
        tick();
    endtask

    task automatic ack();
        bus.calc_ack = 1'b1;
        tick();
        bus.calc_ack = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        #1;
        total_cnt++; if (bus.KeyRd !== 1'b0) $display("FAIL rst_keyrd got %0d want 0", bus.KeyRd); else pass_cnt++;
        total_cnt++; if (bus.calc_req !== 1'b0) $display("FAIL rst_req got %0d want 0", bus.calc_req); else pass_cnt++;
        total_cnt++; if (bus.operand_a !== 16'sd0) $display("FAIL rst_a got %0d want 0", bus.operand_a); else pass_cnt++;
        total_cnt++; if (bus.operand_b !== 16'sd0) $display("FAIL rst_b got %0d want 0", bus.operand_b); else pass_cnt++;
        total_cnt++; if (bus.op_code !== 3'd0) $display("FAIL rst_op got %0d want 0", bus.op_code); else pass_cnt++;
        total_cnt++; if (bus.display_value !== 16'sd0) $display("FAIL rst_disp got %0d want 0", bus.display_value); else pass_cnt++;
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_add();
        press(4'd1, 3'd0, 1'b0);
        press(4'd2, 3'd0, 1'b0);
        total_cnt++; if (bus.display_value !== 16'sd12) $display("FAIL add_disp_a got %0d want 12", bus.display_value); else pass_cnt++;
        press(4'd0, 3'd1, 1'b0);
        press(4'd3, 3'd0, 1'b0);
        press(4'd0, 3'd0, 1'b1);
        total_cnt++; if (bus.calc_req !== 1'b1) $display("FAIL add_req got %0d want 1", bus.calc_req); else pass_cnt++;
        total_cnt++; if (bus.operand_a !== 16'sd12) $display("FAIL add_a got %0d want 12", bus.operand_a); else pass_cnt++;
        total_cnt++; if (bus.operand_b !== 16'sd3) $display("FAIL add_b got %0d want 3", bus.operand_b); else pass_cnt++;
        total_cnt++; if (bus.op_code !== 3'b001) $display("FAIL add_op got %0d want 1", bus.op_code); else pass_cnt++;
        total_cnt++; if (bus.display_value !== 16'sd3) $display("FAIL add_disp_b got %0d want 3", bus.display_value); else pass_cnt++;
        repeat (3) tick();
        total_cnt++;
        if (bus.calc_req !== 1'b1 || bus.operand_a !== 16'sd12 || bus.operand_b !== 16'sd3)
            $display("FAIL add_hold req=%0d a=%0d b=%0d want 1/12/3", bus.calc_req, bus.operand_a, bus.operand_b);
        else pass_cnt++;
        ack();
        total_cnt++; if (bus.calc_req !== 1'b0) $display("FAIL add_req_drop got %0d want 0", bus.calc_req); else pass_cnt++;
        total_cnt++;
        if (bus.operand_a !== 16'sd0 || bus.operand_b !== 16'sd0)
            $display("FAIL add_clear a=%0d b=%0d want 0/0", bus.operand_a, bus.operand_b);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_negative();
        press(4'd0, 3'd2, 1'b0);
        press(4'd5, 3'd0, 1'b0);
        total_cnt++; if (bus.display_value !== -16'sd5) $display("FAIL neg_disp_a got %0d want -5", bus.display_value); else pass_cnt++;
        press(4'd0, 3'd3, 1'b0);
        press(4'd0, 3'd2, 1'b0);
        press(4'd7, 3'd0, 1'b0);
        press(4'd0, 3'd0, 1'b1);
        total_cnt++; if (bus.operand_a !== -16'sd5) $display("FAIL neg_a got %0d want -5", bus.operand_a); else pass_cnt++;
        total_cnt++; if (bus.operand_b !== -16'sd7) $display("FAIL neg_b got %0d want -7", bus.operand_b); else pass_cnt++;
        total_cnt++; if (bus.op_code !== 3'b011) $display("FAIL neg_op got %0d want 3", bus.op_code); else pass_cnt++;
        total_cnt++; if (bus.calc_req !== 1'b1) $display("FAIL neg_req got %0d want 1", bus.calc_req); else pass_cnt++;
        ack();
        tick();
    endtask

    task automatic test_saturate();
        press(4'd3, 3'd0, 1'b0);
        press(4'd2, 3'd0, 1'b0);
        press(4'd7, 3'd0, 1'b0);
        press(4'd6, 3'd0, 1'b0);
        press(4'd7, 3'd0, 1'b0);
        press(4'd9, 3'd0, 1'b0);
        total_cnt++; if (bus.operand_a !== 16'sd32767) $display("FAIL sat_a got %0d want 32767", bus.operand_a); else pass_cnt++;
        press(4'd12, 3'd0, 1'b0);
        total_cnt++; if (bus.operand_a !== 16'sd32767) $display("FAIL invalid_digit got %0d want 32767", bus.operand_a); else pass_cnt++;
        press(4'd0, 3'd0, 1'b1);
        total_cnt++; if (bus.calc_req !== 1'b0) $display("FAIL eq_in_a got %0d want 0", bus.calc_req); else pass_cnt++;
        press(4'd0, 3'd4, 1'b0);
        total_cnt++; if (bus.display_value !== 16'sd0) $display("FAIL sat_clear got %0d want 0", bus.display_value); else pass_cnt++;
    endtask

    task automatic test_key_hold();
        int pulses;
        pulses = 0;
        bus.keypad_input = 4'd1;
        bus.KeyRdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.KeyRd === 1'b1) pulses++;
        end
        total_cnt++; if (pulses != 1) $display("FAIL hold_pulses1 got %0d want 1", pulses); else pass_cnt++;
        total_cnt++; if (bus.display_value !== 16'sd1) $display("FAIL hold_disp1 got %0d want 1", bus.display_value); else pass_cnt++;
        bus.KeyRdy = 1'b0;
        tick();
        bus.KeyRdy = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.KeyRd === 1'b1) pulses++;
        end
        total_cnt++; if (pulses != 1) $display("FAIL hold_pulses2 got %0d want 1", pulses); else pass_cnt++;
        total_cnt++; if (bus.display_value !== 16'sd11) $display("FAIL hold_disp2 got %0d want 11", bus.display_value); else pass_cnt++;
        bus.KeyRdy = 1'b0;
        bus.keypad_input = 4'd0;
        tick();
    endtask

    task automatic test_backpressure();
        int pulses;
        bit req_low;
        press(4'd0, 3'd1, 1'b0);
        press(4'd2, 3'd0, 1'b0);
        press(4'd0, 3'd0, 1'b1);
        pulses = 0;
        req_low = 1'b0;
        bus.keypad_input = 4'd5;
        bus.KeyRdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.KeyRd === 1'b1) pulses++;
            if (bus.calc_req !== 1'b1) req_low = 1'b1;
        end
        total_cnt++; if (pulses != 0) $display("FAIL bp_keyrd got %0d pulses want 0", pulses); else pass_cnt++;
        total_cnt++; if (req_low) $display("FAIL bp_req_hold got low want 1"); else pass_cnt++;
        total_cnt++; if (bus.operand_a !== 16'sd11 || bus.operand_b !== 16'sd2)
            $display("FAIL bp_operands a=%0d b=%0d want 11/2", bus.operand_a, bus.operand_b); else pass_cnt++;
        ack();
        total_cnt++; if (bus.KeyRd !== 1'b0) $display("FAIL bp_keyrd_ack_edge got %0d want 0", bus.KeyRd); else pass_cnt++;
        tick();
        total_cnt++; if (bus.KeyRd !== 1'b1) $display("FAIL bp_keyrd_after got %0d want 1", bus.KeyRd); else pass_cnt++;
        total_cnt++; if (bus.display_value !== 16'sd5) $display("FAIL bp_disp got %0d want 5", bus.display_value); else pass_cnt++;
        bus.KeyRdy = 1'b0;
        bus.keypad_input = 4'd0;
        tick();
        press(4'd0, 3'd4, 1'b0);
    endtask

    task automatic test_clear_and_reset();
        press(4'd9, 3'd0, 1'b0);
        press(4'd0, 3'd1, 1'b0);
        press(4'd4, 3'd0, 1'b0);
        total_cnt++; if (bus.display_value !== 16'sd4) $display("FAIL clr_pre_disp got %0d want 4", bus.display_value); else pass_cnt++;
        press(4'd0, 3'd4, 1'b0);
        total_cnt++;
        if (bus.operand_a !== 16'sd0 || bus.operand_b !== 16'sd0 || bus.op_code !== 3'd0 || bus.display_value !== 16'sd0)
            $display("FAIL clr_outputs a=%0d b=%0d op=%0d disp=%0d want 0/0/0/0",
                     bus.operand_a, bus.operand_b, bus.op_code, bus.display_value);
        else pass_cnt++;
        press(4'd6, 3'd0, 1'b0);
        total_cnt++; if (bus.display_value !== 16'sd6) $display("FAIL clr_state_a got %0d want 6", bus.display_value); else pass_cnt++;
        press(4'd0, 3'd1, 1'b0);
        press(4'd8, 3'd0, 1'b0);
        press(4'd0, 3'd0, 1'b1);
        total_cnt++; if (bus.calc_req !== 1'b1) $display("FAIL rreq_pre got %0d want 1", bus.calc_req); else pass_cnt++;
        nRST = 1'b0;
        #1;
        total_cnt++; if (bus.calc_req !== 1'b0) $display("FAIL rreq_drop got %0d want 0", bus.calc_req); else pass_cnt++;
        total_cnt++;
        if (bus.operand_a !== 16'sd0 || bus.operand_b !== 16'sd0 || bus.op_code !== 3'd0 || bus.display_value !== 16'sd0)
            $display("FAIL rreq_outputs a=%0d b=%0d op=%0d disp=%0d want 0/0/0/0",
                     bus.operand_a, bus.operand_b, bus.op_code, bus.display_value);
        else pass_cnt++;
        nRST = 1'b1;
        tick();
        press(4'd3, 3'd0, 1'b0);
        total_cnt++; if (bus.display_value !== 16'sd3 || bus.calc_req !== 1'b0)
            $display("FAIL rreq_after disp=%0d req=%0d want 3/0", bus.display_value, bus.calc_req); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        nRST               = 1'b1;
        bus.KeyRdy         = 1'b0;
        bus.keypad_input   = 4'd0;
        bus.operator_input = 3'd0;
        bus.equal_input    = 1'b0;
        bus.calc_ack       = 1'b0;
        #2;
        test_reset();
        test_add();
        test_negative();
        test_saturate();
        test_key_hold();
        test_backpressure();
        test_clear_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
